spike_event_encoder: RTL
========================

# spike_event_encoder

Downstream consumer of the four spike detector flags (NEO, ADO, ASO, ED). The block qualifies coincident detections by a configurable vote threshold and suppresses retriggers with a refractory window. Each qualified event is stamped with a free-running cycle timestamp and queued in a FIFO. Events drain through a valid/ready stream toward the segmentation and packetising back end.

## Interface
- TS_W, 32: timestamp width in bits, range 8..32.
- FIFO_DEPTH, 16: event FIFO depth in entries; power of two, at least 2.
- VOTE_MIN, 1: minimum number of simultaneously asserted flags that qualifies an event, range 1..4.
- REFRACT, 8: cycles ignored after a qualified event, range 0..65535; 0 means no suppression.

Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- spike_neo  in  1  NEO detector flag.
- spike_ado  in  1  ADO detector flag.
- spike_aso  in  1  ASO detector flag.
- spike_ed  in  1  ED detector flag.
- out_valid  out  1  FIFO head holds a record.
- out_ready  in  1  consumer accepts the record.
- out_data  out  TS_W+4  event record; [TS_W+3:TS_W] is the mask {neo,ado,aso,ed}, [TS_W-1:0] is the timestamp.
- overflow  out  1  sticky; set when any qualified event is dropped.

## Operation
- ts_cnt increments every cycle. It wraps from 2^TS_W−1 to 0 and is 0 in the first cycle after reset release.
- Stage 1 registers the four flags and the current ts_cnt together.
- Stage 2 computes popcount(mask). The event qualifies when popcount ≥ VOTE_MIN and the refractory counter is 0.
- Qualification loads the refractory counter with REFRACT. The counter decrements each cycle toward 0. Flags are ignored while it is nonzero.
- The refractory window starts even if the event is dropped.
- A qualified event is pushed as {mask, stamped ts}.
- Push when full with no pop in the same cycle: the record is dropped and overflow is set.
- Push when full with a simultaneous pop (out_valid & out_ready): the push is accepted and no drop occurs.
- Pop occurs on out_valid & out_ready. out_data is not checked while out_valid is 0.
- Assertion of rst at any point clears the FIFO, ts_cnt, the refractory counter, the stage registers and overflow. In-flight records are discarded.

## Timing
- Reset values: out_valid 0, out_data 0, overflow 0.
- Flags asserted in cycle N produce a record stamped with the ts_cnt value of cycle N. The record is written at the end of cycle N+1 and is visible with out_valid=1 in cycle N+2 if the FIFO was empty.
- Throughput is one push and one pop per cycle.
- With REFRACT=R, a qualified event in cycle N means the earliest next event is in cycle N+R+1.
- out_data and out_valid are registered. Once asserted, out_valid and out_data hold stable until the record is accepted.

## Configuration
- SPIKE_ENC_DROP_CNT_EN defined: adds output drop_cnt, 16 bits. It counts dropped events, saturates at 0xFFFF and is reset to 0.
- Not defined: no drop_cnt port and no counter logic. Only overflow reports loss.

## Structure
- Package spike_enc_pkg holds:
  - detector bit indices: NEO=3, ADO=2, ASO=1, ED=0;
  - MASK_W=4;
  - the record field offset helpers.
- Sub-module spike_event_fifo: a synchronous FIFO with registered read outputs, parameterised by width and depth, exposing full/empty.

## Test plan
- Reset release, all flags held low for 100 cycles → out_valid stays 0 and overflow stays 0.
- spike_neo high for one cycle, at ts=10, VOTE_MIN=1 → out_valid rises 2 cycles later; out_data = {4'b1000, 32'd10}.
- VOTE_MIN=2:
  - spike_ado alone → no record;
  - spike_ado and spike_ed together at ts=50 → record {4'b0101, 50}.
- REFRACT=8, flags high for 20 consecutive cycles starting at ts=100 → records at ts 100, 109 and 118 only.
- out_ready=0, FIFO_DEPTH=16, 20 spaced events → 16 records retained, overflow=1, drop_cnt=4 (macro on). Then out_ready=1 → the 16 records drain in timestamp order.
- TS_W=8, events around the wrap point; rst pulsed low mid-drain → timestamps 254, 255, 0 are recorded correctly, and after the reset pulse out_valid=0 and the FIFO is empty.

Source files
------------

// File: rtl/spike_enc_pkg.sv
// Shared definitions for the spike event encoder: detector bit positions,
// mask width and helpers describing the {mask, timestamp} record layout.
package spike_enc_pkg;

  localparam int MASK_W = 4;
  localparam int NEO    = 3;
  localparam int ADO    = 2;
  localparam int ASO    = 1;
  localparam int ED     = 0;
  localparam int REFR_W = 16;

  function automatic int rec_w(input int ts_w);
    return ts_w + MASK_W;
  endfunction

  function automatic int rec_mask_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int rec_mask_msb(input int ts_w);
    return ts_w + MASK_W - 1;
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous FIFO whose head entry sits in a registered output stage;
// a push into an empty FIFO bypasses storage and lands directly in that stage.
module spike_event_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              pop, accept, refill, bypass, mem_wr, mem_rd;

  // Occupancy counts storage plus the head stage, so DEPTH records fit in total.
  always_comb begin
    pop          = head_valid_q & pop_ready;
    full         = (mem_cnt_q + CNT_W'(head_valid_q)) == CNT_W'(DEPTH);
    accept       = push & (~full | pop);
    refill       = ~head_valid_q | pop;
    mem_rd       = refill & (mem_cnt_q != '0);
    bypass       = refill & (mem_cnt_q == '0) & accept;
    mem_wr       = accept & ~bypass;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    if (refill) begin
      head_valid_d = mem_rd | bypass;
      if (mem_rd) begin
        head_data_d = mem_q[rd_ptr_q];
      end else if (bypass) begin
        head_data_d = push_data;
      end
    end
    wr_ptr_d  = wr_ptr_q + PTR_W'(mem_wr);
    rd_ptr_d  = rd_ptr_q + PTR_W'(mem_rd);
    mem_cnt_d = mem_cnt_q + CNT_W'(mem_wr) - CNT_W'(mem_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign rd_data = head_data_q;
  assign empty   = ~head_valid_q;

endmodule

// File: rtl/spike_event_encoder.sv
// Qualifies coincident detector flags by vote and refractory window, stamps
// them and queues them for the back end. SPIKE_ENC_DROP_CNT_EN adds drop_cnt.
module spike_event_encoder
  import spike_enc_pkg::*;
#(
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int VOTE_MIN   = 1,
  parameter int REFRACT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_neo,
  input  logic             spike_ado,
  input  logic             spike_aso,
  input  logic             spike_ed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TS_W+3:0]  out_data,
  output logic             overflow
`ifdef SPIKE_ENC_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int REC_W    = rec_w(TS_W);
  localparam int MASK_LSB = rec_mask_lsb(TS_W);
  localparam int MASK_MSB = rec_mask_msb(TS_W);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [MASK_W-1:0] mask_p1_q, mask_p1_d;
  logic [TS_W-1:0]   ts_p1_q, ts_p1_d;
  logic [REFR_W-1:0] refr_q, refr_d;
  logic              overflow_q, overflow_d;
  logic              qualify, drop, fifo_full, fifo_empty;
  logic [REC_W-1:0]  push_data;

  function automatic logic [2:0] popcount(input logic [MASK_W-1:0] m);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < MASK_W; i++) begin
      cnt = cnt + 3'(m[i]);
    end
    return cnt;
  endfunction

  // Stage 1: capture flags together with the timestamp of the same cycle.
  always_comb begin
    ts_d                 = ts_q + TS_W'(1);
    mask_p1_d            = '0;
    mask_p1_d[NEO]       = spike_neo;
    mask_p1_d[ADO]       = spike_ado;
    mask_p1_d[ASO]       = spike_aso;
    mask_p1_d[ED]        = spike_ed;
    ts_p1_d              = ts_q;
  end

  // Stage 2: vote, refractory gating and push; the window restarts even if the push is dropped.
  always_comb begin
    qualify = (int'(popcount(mask_p1_q)) >= VOTE_MIN) && (refr_q == '0);
    refr_d  = refr_q;
    if (qualify) begin
      refr_d = REFR_W'(REFRACT);
    end else if (refr_q != '0) begin
      refr_d = refr_q - REFR_W'(1);
    end
    push_data                    = '0;
    push_data[MASK_MSB:MASK_LSB] = mask_p1_q;
    push_data[TS_W-1:0]          = ts_p1_q;
    drop       = qualify & fifo_full & ~(out_valid & out_ready);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      mask_p1_q  <= '0;
      ts_p1_q    <= '0;
      refr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      mask_p1_q  <= mask_p1_d;
      ts_p1_q    <= ts_p1_d;
      refr_q     <= refr_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SPIKE_ENC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  spike_event_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (qualify),
    .push_data (push_data),
    .pop_ready (out_ready),
    .rd_data   (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule
